// File: rtl/cache_ctrl.sv
// Miss-handling controller for a 2-way, 32-set, 4-word-line data cache: hit completion, dirty write-back, refill, replay.
// Optional hit/miss/write-back counters are built when CACHE_CTRL_STAT_EN is defined.
module cache_ctrl #(
  parameter int ADDR_BITS           = 32,
  parameter int TAG_BITS            = 23,
  parameter int SET_INDEX_WIDTH     = 5,
  parameter int ELEMENT_WORDS_WIDTH = 2,
  parameter int STAT_WIDTH          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_BITS-1:0]  cpu_addr,
  input  logic [2:0]            cpu_u_b_h_w,
  input  logic [31:0]           cpu_din,
  output logic [31:0]           cpu_dout,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  output logic [ADDR_BITS-1:0]  cache_addr,
  output logic                  cache_load,
  output logic                  cache_store,
  output logic                  cache_edit,
  output logic                  cache_invalid,
  output logic [2:0]            cache_u_b_h_w,
  output logic [31:0]           cache_din,
  input  logic                  cache_hit,
  input  logic                  cache_valid,
  input  logic                  cache_dirty,
  input  logic [31:0]           cache_dout,
  input  logic [TAG_BITS-1:0]   cache_tag,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [31:0]           mem_dout,
  input  logic [31:0]           mem_din,
  input  logic                  mem_ack
`ifdef CACHE_CTRL_STAT_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses,
  output logic [STAT_WIDTH-1:0] stat_writebacks
`endif
);

  localparam int         OFF_LSB = ELEMENT_WORDS_WIDTH + 2;
  localparam logic [2:0] F_WORD  = 3'b010;

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_WB_RD, S_WB_WR, S_FILL, S_REPLAY} state_t;

  state_t                         state, state_nx;
  logic [ELEMENT_WORDS_WIDTH-1:0] cnt;
  logic                           cnt_last;
  logic [ADDR_BITS-1:0]           req_addr;
  logic [31:0]                    req_din;
  logic [2:0]                     req_ubhw;
  logic                           req_we;
  logic [TAG_BITS-1:0]            victim_tag;
  logic [31:0]                    wb_data;
  logic                           wb_first;
  logic [ADDR_BITS-1:0]           fill_addr;
  logic [ADDR_BITS-1:0]           wb_addr;

  assign cnt_last      = (cnt == '1);
  assign fill_addr     = {req_addr[ADDR_BITS-1:OFF_LSB], cnt, 2'b00};
  assign wb_addr       = {victim_tag, req_addr[OFF_LSB+SET_INDEX_WIDTH-1:OFF_LSB], cnt, 2'b00};
  assign cache_invalid = 1'b0;
  assign cpu_stall     = (state != S_IDLE) || cpu_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_din    <= '0;
      req_ubhw   <= '0;
      req_we     <= 1'b0;
      victim_tag <= '0;
      wb_data    <= '0;
      wb_first   <= 1'b0;
    end else begin
      state    <= state_nx;
      wb_first <= (state == S_WB_RD);
      case (state)
        S_IDLE: if (cpu_req) begin
          req_addr <= cpu_addr;
          req_din  <= cpu_din;
          req_ubhw <= cpu_u_b_h_w;
          req_we   <= cpu_we;
        end
        S_TAG: if (!cache_hit) begin
          cnt <= '0;
          if (cache_valid && cache_dirty) victim_tag <= cache_tag;
        end
        S_WB_WR: begin
          // Victim word is only on cache_dout during the first cycle; hold it for slow memories.
          if (wb_first) wb_data <= cache_dout;
          if (mem_ack) cnt <= cnt + ELEMENT_WORDS_WIDTH'(1);
        end
        S_FILL: if (mem_ack) cnt <= cnt + ELEMENT_WORDS_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cpu_req) state_nx = S_TAG;
      S_TAG: begin
        if (cache_hit)                       state_nx = S_IDLE;
        else if (cache_valid && cache_dirty) state_nx = S_WB_RD;
        else                                 state_nx = S_FILL;
      end
      S_WB_RD:  state_nx = S_WB_WR;
      S_WB_WR:  if (mem_ack) state_nx = cnt_last ? S_FILL : S_WB_RD;
      S_FILL:   if (mem_ack && cnt_last) state_nx = S_REPLAY;
      S_REPLAY: state_nx = S_TAG;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_ack       = 1'b0;
    cpu_dout      = '0;
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_store   = 1'b0;
    cache_edit    = 1'b0;
    cache_u_b_h_w = '0;
    cache_din     = '0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_dout      = '0;
    case (state)
      S_IDLE: if (cpu_req) begin
        cache_addr    = cpu_addr;
        cache_load    = !cpu_we;
        cache_edit    = cpu_we;
        cache_u_b_h_w = cpu_u_b_h_w;
        cache_din     = cpu_din;
      end
      S_TAG: if (cache_hit) begin
        cpu_ack  = 1'b1;
        cpu_dout = cache_dout;
      end
      S_WB_RD: begin
        cache_addr    = fill_addr;
        cache_u_b_h_w = F_WORD;
      end
      S_WB_WR: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wb_addr;
        mem_dout = wb_first ? cache_dout : wb_data;
      end
      S_FILL: begin
        mem_cs   = 1'b1;
        mem_addr = fill_addr;
        if (mem_ack) begin
          cache_store   = 1'b1;
          cache_addr    = fill_addr;
          cache_din     = mem_din;
          cache_u_b_h_w = F_WORD;
        end
      end
      S_REPLAY: begin
        cache_addr    = req_addr;
        cache_load    = !req_we;
        cache_edit    = req_we;
        cache_u_b_h_w = req_ubhw;
        cache_din     = req_din;
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_STAT_EN
  logic replay_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      replay_tag      <= 1'b0;
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      replay_tag <= (state == S_REPLAY);
      if (state == S_TAG) begin
        if (cache_hit && !replay_tag && stat_hits != '1)
          stat_hits <= stat_hits + STAT_WIDTH'(1);
        if (!cache_hit && stat_misses != '1)
          stat_misses <= stat_misses + STAT_WIDTH'(1);
        if (state_nx == S_WB_RD && stat_writebacks != '1)
          stat_writebacks <= stat_writebacks + STAT_WIDTH'(1);
      end
    end
  end
`else
  // statistics counters not built
`endif

endmodule
